// File: rtl/rx_matrix_loader.sv
// rx_matrix_loader
// Frame controller between the UART receiver and the NPU matrix buffer RAM.
// It detects the rising edge of the receiver's byte-done signal and parses the
// byte stream:
//   SYNC_BYTE, rows, cols, rows*cols payload bytes, XOR checksum
// Payload bytes are written row-major (index r*cols + c) into the buffer.
// The compute sequencer is told whether each frame completed or was rejected.
//
// Ports
//   clk, rst           clock and asynchronous active-low reset
//   rxDone, rxData     receiver byte-done level and byte; a byte is taken only
//                      on the rising edge of rxDone
//   mem_we/addr/wdata  buffer write port, one single-cycle strobe per payload byte
//   busy               high whenever the parser is inside a frame
//   frame_done         one-cycle pulse when a frame is accepted
//   frame_error        one-cycle pulse when a frame is rejected
//   err_code           latched cause: 0 none, 1 bad dims, 2 checksum, 3 timeout
//   rows_o, cols_o     dimensions of the last accepted frame
//
// Handshake: there is no back-pressure. A byte event is rxDone=1 while rxDone
// was 0 in the previous cycle. rxData is sampled in that cycle. Every effect of
// the byte is visible on the registered outputs one cycle later.
module rx_matrix_loader #(
    parameter int          ADDR_W    = 8,
    parameter int          MAX_DIM   = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          TIMEOUT   = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxDone,
    input  logic [7:0]        rxData,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_error,
    output logic [1:0]        err_code,
    output logic [7:0]        rows_o,
    output logic [7:0]        cols_o
);

    localparam int         TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0] MAX_DIM_B = 8'(MAX_DIM);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR_R   = 3'd1;
    localparam logic [2:0] S_HDR_C   = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              rx_done_prev_q, rx_done_prev_d;
    logic [7:0]        rows_q, rows_d;
    logic [7:0]        cols_q, cols_d;
    logic [15:0]       total_q, total_d;
    logic [15:0]       idx_q, idx_d;
    logic [7:0]        chk_q, chk_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_error_q, frame_error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [7:0]        rows_o_q, rows_o_d;
    logic [7:0]        cols_o_q, cols_o_d;

    logic              byte_ev;
    logic              timed_out;
    logic [15:0]       idx_inc;

    assign byte_ev   = rxDone & ~rx_done_prev_q;
    // The timer holds the number of cycles since the last byte event, minus one.
    // The check fires in the cycle that would bring the count to TIMEOUT, so the
    // error pulse is visible exactly TIMEOUT cycles after that byte's own outputs.
    assign timed_out = (state_q != S_IDLE) && (timer_q == TMO_LAST);
    assign idx_inc   = idx_q + 16'd1;

    always_comb begin
        state_d        = state_q;
        rx_done_prev_d = rxDone;
        rows_d         = rows_q;
        cols_d         = cols_q;
        total_d        = total_q;
        idx_d          = idx_q;
        chk_d          = chk_q;
        timer_d        = (state_q == S_IDLE || byte_ev) ? '0 : timer_q + TW'(1);
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        frame_done_d   = 1'b0;
        frame_error_d  = 1'b0;
        err_code_d     = err_code_q;
        rows_o_d       = rows_o_q;
        cols_o_d       = cols_o_q;

        if (timed_out) begin
            // A byte arriving in this same cycle is deliberately dropped.
            frame_error_d = 1'b1;
            err_code_d    = 2'd3;
            state_d       = S_IDLE;
            timer_d       = '0;
        end else if (byte_ev) begin
            case (state_q)
                S_IDLE: begin
                    if (rxData == SYNC_BYTE) state_d = S_HDR_R;
                end
                S_HDR_R: begin
                    rows_d  = rxData;
                    state_d = S_HDR_C;
                end
                S_HDR_C: begin
                    cols_d = rxData;
                    if (rows_q == 8'd0 || rows_q > MAX_DIM_B ||
                        rxData == 8'd0 || rxData > MAX_DIM_B) begin
                        frame_error_d = 1'b1;
                        err_code_d    = 2'd1;
                        state_d       = S_IDLE;
                    end else begin
                        total_d = {8'd0, rows_q} * {8'd0, rxData};
                        idx_d   = 16'd0;
                        chk_d   = 8'd0;
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = idx_q[ADDR_W-1:0];
                    mem_wdata_d = rxData;
                    chk_d       = chk_q ^ rxData;
                    idx_d       = idx_inc;
                    if (idx_inc == total_q) state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (rxData == chk_q) begin
                        frame_done_d = 1'b1;
                        err_code_d   = 2'd0;
                        rows_o_d     = rows_q;
                        cols_o_d     = cols_q;
                    end else begin
                        frame_error_d = 1'b1;
                        err_code_d    = 2'd2;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            // Starting high means an rxDone level already high at release is not a byte.
            rx_done_prev_q <= 1'b1;
            rows_q         <= '0;
            cols_q         <= '0;
            total_q        <= '0;
            idx_q          <= '0;
            chk_q          <= '0;
            timer_q        <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            frame_done_q   <= 1'b0;
            frame_error_q  <= 1'b0;
            err_code_q     <= '0;
            rows_o_q       <= '0;
            cols_o_q       <= '0;
        end else begin
            state_q        <= state_d;
            rx_done_prev_q <= rx_done_prev_d;
            rows_q         <= rows_d;
            cols_q         <= cols_d;
            total_q        <= total_d;
            idx_q          <= idx_d;
            chk_q          <= chk_d;
            timer_q        <= timer_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            frame_done_q   <= frame_done_d;
            frame_error_q  <= frame_error_d;
            err_code_q     <= err_code_d;
            rows_o_q       <= rows_o_d;
            cols_o_q       <= cols_o_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign err_code    = err_code_q;
    assign rows_o      = rows_o_q;
    assign cols_o      = cols_o_q;

endmodule

// File: tb/tb_rx_matrix_loader.sv
// Self-checking bench for rx_matrix_loader. Frames are built at frame level:
// each transmitted byte gets the output snapshot expected one cycle after its
// rising edge. The snapshot is compared with what the DUT shows at that point.
module tb_rx_matrix_loader;
    localparam int         ADDR_W  = 8;
    localparam int         MAX_DIM = 16;
    localparam int         TIMEOUT = 40;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic              clk;
    logic              rst;
    logic              rxDone;
    logic [7:0]        rxData;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              frame_done;
    logic              frame_error;
    logic [1:0]        err_code;
    logic [7:0]        rows_o;
    logic [7:0]        cols_o;

    rx_matrix_loader #(
        .ADDR_W(ADDR_W), .MAX_DIM(MAX_DIM), .SYNC_BYTE(SYNC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .rxDone(rxDone), .rxData(rxData),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .frame_done(frame_done), .frame_error(frame_error),
        .err_code(err_code), .rows_o(rows_o), .cols_o(cols_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // strobe monitor, sampled on the inactive edge
    int we_cycles = 0, done_cycles = 0, err_cycles = 0, both_cycles = 0;
    always @(negedge clk) begin
        if (mem_we === 1'b1) we_cycles++;
        if (frame_done === 1'b1) done_cycles++;
        if (frame_error === 1'b1) err_cycles++;
        if (frame_done === 1'b1 && frame_error === 1'b1) both_cycles++;
    end

    // reference model state
    logic [7:0]  tx_q[$];
    logic [37:0] exp_q[$];
    logic [37:0] obs_q[$];
    logic [7:0]  exp_rows = 8'd0;
    logic [7:0]  exp_cols = 8'd0;
    logic [1:0]  exp_code = 2'd0;
    int          exp_done_n = 0;
    int          exp_err_n  = 0;

    function automatic logic [37:0] mk(input logic we, input logic [7:0] addr,
                                       input logic [7:0] data, input logic done,
                                       input logic err, input logic [1:0] code,
                                       input logic bsy, input logic [7:0] r,
                                       input logic [7:0] c);
        return {we, we ? addr : 8'h00, we ? data : 8'h00, done, err, code, bsy, r, c};
    endfunction

    function automatic logic [37:0] pack_obs();
        return mk(mem_we, mem_addr, mem_wdata, frame_done, frame_error, err_code,
                  busy, rows_o, cols_o);
    endfunction

    task automatic push_idle(input logic [7:0] b);
        tx_q.push_back(b);
        exp_q.push_back(mk(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, exp_code, 1'b0, exp_rows, exp_cols));
    endtask

    task automatic push_noise(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            while (b == SYNC) b = 8'($urandom);
            push_idle(b);
        end
    endtask

    // Builds one complete frame. bad_xor = 0 gives a correct checksum.
    task automatic add_frame(input logic [7:0] r, input logic [7:0] c,
                             input logic [7:0] bad_xor, input bit fixed);
        logic [7:0] chk;
        logic [7:0] d;
        bit         dims_ok;
        int         n;
        chk = 8'h00;
        dims_ok = (r != 0) && (c != 0) && (r <= MAX_DIM) && (c <= MAX_DIM);
        tx_q.push_back(SYNC);
        exp_q.push_back(mk(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, exp_code, 1'b1, exp_rows, exp_cols));
        tx_q.push_back(r);
        exp_q.push_back(mk(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, exp_code, 1'b1, exp_rows, exp_cols));
        tx_q.push_back(c);
        if (!dims_ok) begin
            exp_code = 2'd1;
            exp_err_n++;
            exp_q.push_back(mk(1'b0, 8'h0, 8'h0, 1'b0, 1'b1, exp_code, 1'b0, exp_rows, exp_cols));
            return;
        end
        exp_q.push_back(mk(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, exp_code, 1'b1, exp_rows, exp_cols));
        n = int'(r) * int'(c);
        for (int k = 0; k < n; k++) begin
            d = fixed ? 8'(8'h11 * (k + 1)) : 8'($urandom);
            chk ^= d;
            tx_q.push_back(d);
            exp_q.push_back(mk(1'b1, 8'(k), d, 1'b0, 1'b0, exp_code, 1'b1, exp_rows, exp_cols));
        end
        tx_q.push_back(chk ^ bad_xor);
        if (bad_xor == 8'h00) begin
            exp_rows = r;
            exp_cols = c;
            exp_code = 2'd0;
            exp_done_n++;
            exp_q.push_back(mk(1'b0, 8'h0, 8'h0, 1'b1, 1'b0, exp_code, 1'b0, exp_rows, exp_cols));
        end else begin
            exp_code = 2'd2;
            exp_err_n++;
            exp_q.push_back(mk(1'b0, 8'h0, 8'h0, 1'b0, 1'b1, exp_code, 1'b0, exp_rows, exp_cols));
        end
    endtask

    // driver: rising edge on a negedge, snapshot one cycle later, optional long high level
    task automatic drive_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rxDone = 1'b1;
        rxData = b;
        @(negedge clk);
        obs_q.push_back(pack_obs());
        for (int i = 0; i < hold; i++) begin
            rxData = 8'($urandom);
            @(negedge clk);
        end
        rxDone = 1'b0;
        rxData = 8'($urandom);
    endtask

    task automatic run_stream(input bit rand_timing);
        logic [7:0] b;
        while (tx_q.size() > 0) begin
            b = tx_q.pop_front();
            if (rand_timing) repeat ($urandom_range(0, 3)) @(negedge clk);
            drive_byte(b, rand_timing ? int'($urandom_range(0, 2)) : 0);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rxDone = 1'b1;
        rxData = SYNC;
        repeat (3) @(negedge clk);
        n_checks++;
        if (pack_obs() !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", pack_obs(), 38'h0);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (pack_obs() !== 38'h0) begin
                n_fail++;
                $display("FAIL held_rxdone cycle %0d: got %h expected %h", i, pack_obs(), 38'h0);
            end
        end
        rxDone = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (we_cycles !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: we_cycles %0d busy %b expected 0 0", we_cycles, busy);
        end
    endtask

    task automatic test_good_frame();
        int we0, dn0;
        we0 = we_cycles;
        dn0 = done_cycles;
        add_frame(8'd2, 8'd2, 8'h00, 1'b1);
        run_stream(1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL good_frame byte %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (rows_o !== 8'd2 || cols_o !== 8'd2 || err_code !== 2'd0 ||
            we_cycles - we0 !== 4 || done_cycles - dn0 !== 1) begin
            n_fail++;
            $display("FAIL good_frame_summary: rows %0d cols %0d code %0d writes %0d done %0d expected 2 2 0 4 1",
                     rows_o, cols_o, err_code, we_cycles - we0, done_cycles - dn0);
        end
    endtask

    task automatic test_bad_checksum();
        int er0;
        er0 = err_cycles;
        add_frame(8'd2, 8'd2, 8'h44, 1'b1);  // checksum byte becomes 00
        run_stream(1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bad_checksum byte %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (rows_o !== 8'd2 || cols_o !== 8'd2 || err_code !== 2'd2 || err_cycles - er0 !== 1) begin
            n_fail++;
            $display("FAIL bad_checksum_summary: rows %0d cols %0d code %0d errs %0d expected 2 2 2 1",
                     rows_o, cols_o, err_code, err_cycles - er0);
        end
    endtask

    task automatic test_bad_dims();
        int we0;
        we0 = we_cycles;
        push_idle(8'h3C);
        add_frame(8'd0, 8'd5, 8'h00, 1'b0);
        add_frame(8'd17, 8'd1, 8'h00, 1'b0);
        add_frame(8'd3, 8'd17, 8'h00, 1'b0);
        add_frame(8'd4, 8'd0, 8'h00, 1'b0);
        run_stream(1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bad_dims byte %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (we_cycles - we0 !== 0 || err_code !== 2'd1) begin
            n_fail++;
            $display("FAIL bad_dims_summary: writes %0d code %0d expected 0 1", we_cycles - we0, err_code);
        end
    endtask

    task automatic test_timeout();
        int early;
        logic [37:0] got;
        logic [37:0] want;
        tx_q.push_back(SYNC);
        exp_q.push_back(mk(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, exp_code, 1'b1, exp_rows, exp_cols));
        tx_q.push_back(8'd1);
        exp_q.push_back(mk(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, exp_code, 1'b1, exp_rows, exp_cols));
        tx_q.push_back(8'd3);
        exp_q.push_back(mk(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, exp_code, 1'b1, exp_rows, exp_cols));
        tx_q.push_back(8'h07);
        exp_q.push_back(mk(1'b1, 8'h0, 8'h07, 1'b0, 1'b0, exp_code, 1'b1, exp_rows, exp_cols));
        // last byte must end with rxDone low at its snapshot, so drive without random timing
        while (tx_q.size() > 0) drive_byte(tx_q.pop_front(), 0);
        early = 0;
        for (int k = 1; k < TIMEOUT; k++) begin
            @(negedge clk);
            if (frame_error !== 1'b0 || busy !== 1'b1) early++;
        end
        // this SYNC lands in the timeout cycle and has to be lost
        rxDone = 1'b1;
        rxData = SYNC;
        @(negedge clk);
        got = pack_obs();
        rxDone = 1'b0;
        exp_code = 2'd3;
        exp_err_n++;
        want = mk(1'b0, 8'h0, 8'h0, 1'b0, 1'b1, exp_code, 1'b0, exp_rows, exp_cols);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL timeout_prefix byte %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL timeout_early: %0d cycles off before the limit, expected 0", early);
        end
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL timeout_pulse: got %h expected %h", got, want);
        end
        // dropped SYNC means these are idle noise, then a fresh frame must parse
        push_idle(8'd1);
        push_idle(8'd1);
        push_idle(8'h55);
        add_frame(8'd1, 8'd3, 8'h00, 1'b0);
        run_stream(1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL timeout_recover byte %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_payload();
        tx_q.push_back(SYNC);
        exp_q.push_back(mk(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, exp_code, 1'b1, exp_rows, exp_cols));
        tx_q.push_back(8'd3);
        exp_q.push_back(mk(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, exp_code, 1'b1, exp_rows, exp_cols));
        tx_q.push_back(8'd3);
        exp_q.push_back(mk(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, exp_code, 1'b1, exp_rows, exp_cols));
        tx_q.push_back(8'h9A);
        exp_q.push_back(mk(1'b1, 8'h0, 8'h9A, 1'b0, 1'b0, exp_code, 1'b1, exp_rows, exp_cols));
        tx_q.push_back(8'h5B);
        exp_q.push_back(mk(1'b1, 8'h1, 8'h5B, 1'b0, 1'b0, exp_code, 1'b1, exp_rows, exp_cols));
        while (tx_q.size() > 0) drive_byte(tx_q.pop_front(), 0);
        rst = 1'b0;
        #1;
        n_checks++;
        if (pack_obs() !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_mid_payload: got %h expected %h", pack_obs(), 38'h0);
        end
        exp_rows = 8'd0;
        exp_cols = 8'd0;
        exp_code = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        add_frame(8'd2, 8'd3, 8'h00, 1'b0);
        run_stream(1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL reset_then_frame byte %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_dim_limits();
        add_frame(8'd16, 8'd16, 8'h00, 1'b0);
        add_frame(8'd1, 8'd1, 8'h00, 1'b0);
        add_frame(8'd1, 8'd16, 8'h00, 1'b0);
        add_frame(8'd16, 8'd1, 8'h3C, 1'b0);
        run_stream(1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL dim_limits byte %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_random_frames();
        logic [7:0] r, c, bx;
        for (int f = 0; f < 25; f++) begin
            push_noise(int'($urandom_range(0, 2)));
            if ($urandom_range(0, 9) == 0) begin
                r = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(17, 255));
                c = 8'($urandom_range(1, 6));
            end else begin
                r = 8'($urandom_range(1, 6));
                c = 8'($urandom_range(1, 6));
            end
            bx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            add_frame(r, c, bx, 1'b0);
        end
        run_stream(1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_frames byte %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // totals since the reset inside test_reset_mid_payload are not separated, so
    // pulse totals are compared over the whole run
    task automatic test_strobes();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (both_cycles !== 0) begin
            n_fail++;
            $display("FAIL strobes_exclusive: %0d cycles with both pulses, expected 0", both_cycles);
        end
        n_checks++;
        if (done_cycles !== exp_done_n || err_cycles !== exp_err_n) begin
            n_fail++;
            $display("FAIL strobe_widths: done %0d err %0d cycles, expected %0d %0d",
                     done_cycles, err_cycles, exp_done_n, exp_err_n);
        end
    endtask

    initial begin
        rst    = 1'b0;
        rxDone = 1'b1;
        rxData = 8'h00;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_dims();
        test_timeout();
        test_reset_mid_payload();
        test_dim_limits();
        test_random_frames();
        test_strobes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_matrix_loader.md
Name: rx_matrix_loader

Overview:
- Frame controller between the UART receiver and the matrix buffer RAM of the NPU.
- Edge-detects the receiver's byte-done strobe and parses a framed byte stream: sync, rows, cols, payload, checksum.
- Writes the payload row-major into the buffer and reports frame completion or error to the compute sequencer.

Parameters:
- ADDR_W, 8, buffer address width; must satisfy MAX_DIM*MAX_DIM <= 2^ADDR_W.
- MAX_DIM, 16, largest legal rows/cols value.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 50000, max clk cycles allowed between bytes inside a frame.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- rxDone  in  1  UART byte-done level/strobe; a byte is taken on its rising edge only
- rxData  in  8  received byte; valid in the cycle the rising edge is detected
- mem_we  out  1  buffer write strobe, one cycle per payload byte
- mem_addr  out  ADDR_W  payload index, row-major (r*cols + c)
- mem_wdata  out  8  payload byte
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse on a good frame
- frame_error  out  1  one-cycle pulse on a rejected frame
- err_code  out  2  latched cause: 0 none, 1 bad dims, 2 checksum, 3 timeout
- rows_o  out  8  rows of last good frame
- cols_o  out  8  cols of last good frame

Behaviour:
- Reset (async, rst=0):
  - All outputs are 0.
  - State is IDLE.
  - Internal rxDone_prev is 1, so a level already high at reset release is not a byte.
  - Any partial frame is discarded; buffer contents are untouched.
- Byte event: rxDone=1 and rxDone_prev=0 in cycle N. rxData is sampled in N.
- Latency: all outputs for a byte event are registered and appear in N+1.
- FSM transitions:
  - IDLE: a byte equal to SYNC_BYTE -> HDR_R. Any other byte is ignored with no error. The timer is stopped.
  - HDR_R: the byte is stored as rows -> HDR_C.
  - HDR_C: the byte is stored as cols.
    - If rows or cols is 0 or greater than MAX_DIM: frame_error, err_code=1 -> IDLE.
    - Otherwise load remaining = rows*cols (16-bit), idx=0, chk=0 -> PAYLOAD.
  - PAYLOAD: each byte gives mem_we=1, mem_addr=idx[ADDR_W-1:0], mem_wdata=byte; chk ^= byte; idx++. After the byte that reaches idx == rows*cols -> CHECK.
  - CHECK: the byte is compared with chk.
    - Equal: frame_done=1, rows_o/cols_o updated, err_code=0.
    - Unequal: frame_error=1, err_code=2; rows_o/cols_o unchanged.
    - Either way -> IDLE.
- Timeout:
  - A cycle counter is cleared on every byte event and in IDLE, and increments in every other state.
  - Reaching TIMEOUT: frame_error=1, err_code=3 -> IDLE.
  - A byte event in that same cycle is dropped.
- Strobe widths: mem_we, frame_done and frame_error each last exactly one cycle. frame_done and frame_error are never high together.
- err_code holds its value until the next frame_done or frame_error.
- Buffer writes are never rolled back: a bad frame can leave a partial overwrite. The consumer reads only after frame_done.
- A held-high rxDone produces only one byte.

Test Plan:
1. rst low, then released with rxDone=1 held -> no activity; busy=0; all outputs 0.
2. Bytes A5,02,02,11,22,33,44,checksum 44 (11^22^33^44) -> mem_we at addr 0..3 with data 11,22,33,44, each one cycle after its edge; then frame_done=1; rows_o=2, cols_o=2; err_code=0.
3. Same frame with checksum 00 -> four writes, then frame_error=1, err_code=2; rows_o/cols_o keep prior values.
4. Bytes 3C,A5,00,05 -> 3C ignored; error after cols byte with err_code=1; no mem_we.
5. A5,01,03,07, then idle for TIMEOUT cycles -> frame_error at exactly TIMEOUT cycles after the last byte; err_code=3; busy=0; next A5 restarts parsing.
6. rst asserted during PAYLOAD -> outputs 0 immediately; a new full frame after release loads from addr 0.
